// File: rtl/fb_pkg.sv
// fb_pkg: shared defaults, buffer index type and controller state
// encoding for the framebuffer ring and its banks.
package fb_pkg;

  localparam int DEF_PIXEL_W      = 4;
  localparam int DEF_ADDR_W       = 19;
  localparam int FRAMEBUFFER_SIZE = 640 * 480;

  typedef logic [1:0] buf_idx_t;

  typedef enum logic [1:0] {
    RENDER,
    WAIT_VSYNC,
    CLEAR
  } fbr_state_t;

endpackage

// File: rtl/framebuffer_ring_if.sv
// framebuffer_ring_if: renderer write ports, scan-out read ports and
// the frame handoff handshake. slave = ring, master = driver side.
interface framebuffer_ring_if
  import fb_pkg::*;
#(
  parameter int PIXEL_W = DEF_PIXEL_W,
  parameter int ADDR_W  = DEF_ADDR_W
);

  logic               bram_en;
  logic               vsync;
  logic [ADDR_W-1:0]  addr_vga;
  logic [PIXEL_W-1:0] data_vga;
  logic [ADDR_W-1:0]  addr_lcd;
  logic [PIXEL_W-1:0] data_lcd;
  logic [ADDR_W-1:0]  addr_wr1;
  logic [ADDR_W-1:0]  addr_wr2;
  logic [PIXEL_W-1:0] data_wr1;
  logic [PIXEL_W-1:0] data_wr2;
  logic               wr1_en;
  logic               wr2_en;
  logic               frame_done;
  logic               back_ready;
  logic               swap_pending;
  logic               swap_pulse;
  buf_idx_t           front_idx;
  buf_idx_t           back_idx;
  logic [7:0]         frames_dropped;

  modport slave (
    input  bram_en, vsync,
    input  addr_vga, addr_lcd,
    input  addr_wr1, addr_wr2,
    input  data_wr1, data_wr2,
    input  wr1_en, wr2_en,
    input  frame_done,
    output data_vga, data_lcd,
    output back_ready, swap_pending,
    output swap_pulse,
    output front_idx, back_idx,
    output frames_dropped
  );

  modport master (
    output bram_en, vsync,
    output addr_vga, addr_lcd,
    output addr_wr1, addr_wr2,
    output data_wr1, data_wr2,
    output wr1_en, wr2_en,
    output frame_done,
    input  data_vga, data_lcd,
    input  back_ready, swap_pending,
    input  swap_pulse,
    input  front_idx, back_idx,
    input  frames_dropped
  );

endinterface

// File: rtl/framebuffer_bank.sv
// framebuffer_bank: true dual-port read-first RAM, 1-cycle read.
// Ports: clk, rst_n (output regs only), en, {we,addr,din,dout}_{a,b}.
module framebuffer_bank #(
  parameter int PIXEL_W = 4,
  parameter int ADDR_W  = 19,
  parameter int DEPTH   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               we_a,
  input  logic [ADDR_W-1:0]  addr_a,
  input  logic [PIXEL_W-1:0] din_a,
  output logic [PIXEL_W-1:0] dout_a,
  input  logic               we_b,
  input  logic [ADDR_W-1:0]  addr_b,
  input  logic [PIXEL_W-1:0] din_b,
  output logic [PIXEL_W-1:0] dout_b
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIXEL_W-1:0] mem [DEPTH];
  logic [AW-1:0]      ia;
  logic [AW-1:0]      ib;
  logic [PIXEL_W-1:0] dout_a_d, dout_a_q;
  logic [PIXEL_W-1:0] dout_b_d, dout_b_q;

  assign ia = addr_a[AW-1:0];
  assign ib = addr_b[AW-1:0];

  if (ADDR_W > AW) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{addr_a[ADDR_W-1:AW],
                         addr_b[ADDR_W-1:AW]};
  end

  always_comb begin
    dout_a_d = dout_a_q;
    dout_b_d = dout_b_q;
    if (en) begin
      dout_a_d = mem[ia];
      dout_b_d = mem[ib];
    end
  end

  // Port B is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we_a) mem[ia] <= din_a;
      if (we_b) mem[ib] <= din_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end

  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;

endmodule

// File: rtl/framebuffer_ring.sv
// framebuffer_ring: 2/3-buffer frame store, vsync-committed swaps,
// optional back-buffer clear. Ports: clock, reset (async low), bus.
module framebuffer_ring
  import fb_pkg::*;
#(
  parameter int PIXEL_W       = DEF_PIXEL_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DEPTH         = FRAMEBUFFER_SIZE,
  parameter int NUM_BUFS      = 2,
  parameter int CLEAR_ON_SWAP = 1,
  parameter int CLEAR_VALUE   = 0
) (
  input logic clock,
  input logic reset,
  framebuffer_ring_if.slave bus
);

  localparam fbr_state_t ACQ_STATE =
    (CLEAR_ON_SWAP != 0) ? CLEAR : RENDER;
  localparam logic [PIXEL_W-1:0] CV = PIXEL_W'(CLEAR_VALUE);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 2);

  fbr_state_t        state_d, state_q;
  buf_idx_t          front_d, front_q;
  buf_idx_t          back_d, back_q;
  buf_idx_t          third_d, third_q;
  buf_idx_t          rd_sel_d, rd_sel_q;
  logic              rdy_vld_d, rdy_vld_q;
  logic              back_ready_d, back_ready_q;
  logic              pend_d, pend_q;
  logic              swap_d, swap_q;
  logic              vsync_d, vsync_q;
  logic [7:0]        drop_d, drop_q;
  logic [ADDR_W-1:0] clr_cnt_d, clr_cnt_q;

  logic vfall;
  logic fd;
  logic clr_act;
  logic clr_last;
  logic wr1_ok;
  logic wr2_ok;

  logic [PIXEL_W-1:0] rd_a [NUM_BUFS];
  logic [PIXEL_W-1:0] rd_b [NUM_BUFS];
  logic [PIXEL_W-1:0] vga_c;
  logic [PIXEL_W-1:0] lcd_c;

  assign vfall    = vsync_q & ~bus.vsync;
  assign fd       = bus.frame_done & back_ready_q;
  assign clr_act  = (state_q == CLEAR);
  assign clr_last = clr_act & bus.bram_en &
                    (clr_cnt_q == CLR_LAST);

  // Same-address dual write: drop port 1 so port 2 wins.
  assign wr1_ok = back_ready_q & bus.wr1_en &
                  ~(bus.wr2_en &
                    (bus.addr_wr1 == bus.addr_wr2));
  assign wr2_ok = back_ready_q & bus.wr2_en;

  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    back_d    = back_q;
    third_d   = third_q;
    rdy_vld_d = rdy_vld_q;
    drop_d    = drop_q;
    clr_cnt_d = clr_cnt_q;
    swap_d    = 1'b0;
    vsync_d   = bus.vsync;
    rd_sel_d  = bus.bram_en ? front_q : rd_sel_q;

    if (clr_act && bus.bram_en)
      clr_cnt_d = clr_cnt_q + ADDR_W'(2);
    if (clr_last) begin
      state_d   = RENDER;
      clr_cnt_d = '0;
    end

    if (NUM_BUFS == 2) begin
      unique case (state_q)
        RENDER: if (fd) state_d = WAIT_VSYNC;
        WAIT_VSYNC: begin
          if (vfall) begin
            front_d   = back_q;
            back_d    = front_q;
            swap_d    = 1'b1;
            state_d   = ACQ_STATE;
            clr_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end else begin
      // third_q is the spare slot; when rdy_vld_q it holds
      // the completed frame waiting for vsync.
      if (fd) begin
        third_d   = back_q;
        back_d    = third_q;
        rdy_vld_d = 1'b1;
        state_d   = ACQ_STATE;
        clr_cnt_d = '0;
        if (rdy_vld_q) drop_d = drop_q + 8'd1;
      end else if (vfall && rdy_vld_q) begin
        front_d   = third_q;
        third_d   = front_q;
        rdy_vld_d = 1'b0;
        swap_d    = 1'b1;
      end
    end

    back_ready_d = (state_d == RENDER);
    pend_d = (NUM_BUFS == 2) ? (state_d == WAIT_VSYNC)
                             : rdy_vld_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ACQ_STATE;
      front_q      <= 2'd0;
      back_q       <= 2'd1;
      third_q      <= 2'd2;
      rd_sel_q     <= 2'd0;
      rdy_vld_q    <= 1'b0;
      back_ready_q <= (ACQ_STATE == RENDER);
      pend_q       <= 1'b0;
      swap_q       <= 1'b0;
      vsync_q      <= 1'b0;
      drop_q       <= '0;
      clr_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      back_q       <= back_d;
      third_q      <= third_d;
      rd_sel_q     <= rd_sel_d;
      rdy_vld_q    <= rdy_vld_d;
      back_ready_q <= back_ready_d;
      pend_q       <= pend_d;
      swap_q       <= swap_d;
      vsync_q      <= vsync_d;
      drop_q       <= drop_d;
      clr_cnt_q    <= clr_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_BUFS; g++) begin : g_bank
    logic               is_back;
    logic               we_a, we_b;
    logic [ADDR_W-1:0]  ad_a, ad_b;
    logic [PIXEL_W-1:0] di_a, di_b;

    // Port A serves VGA / wr1 / clear-even, port B LCD / wr2 /
    // clear-odd; the front bank is never written.
    always_comb begin
      is_back = (back_q == buf_idx_t'(g));
      we_a    = is_back & (clr_act | wr1_ok);
      we_b    = is_back & (clr_act | wr2_ok);
      ad_a    = bus.addr_vga;
      ad_b    = bus.addr_lcd;
      di_a    = bus.data_wr1;
      di_b    = bus.data_wr2;
      if (is_back && clr_act) begin
        ad_a = clr_cnt_q;
        ad_b = clr_cnt_q + ADDR_W'(1);
        di_a = CV;
        di_b = CV;
      end else if (is_back) begin
        ad_a = bus.addr_wr1;
        ad_b = bus.addr_wr2;
      end
    end

    framebuffer_bank #(
      .PIXEL_W (PIXEL_W),
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH)
    ) u_bank (
      .clk    (clock),
      .rst_n  (reset),
      .en     (bus.bram_en),
      .we_a   (we_a),
      .addr_a (ad_a),
      .din_a  (di_a),
      .dout_a (rd_a[g]),
      .we_b   (we_b),
      .addr_b (ad_b),
      .din_b  (di_b),
      .dout_b (rd_b[g])
    );
  end

  // rd_sel_q is front as of the cycle the address was sampled.
  always_comb begin
    vga_c = '0;
    lcd_c = '0;
    for (int i = 0; i < NUM_BUFS; i++) begin
      if (rd_sel_q == buf_idx_t'(i)) begin
        vga_c = rd_a[i];
        lcd_c = rd_b[i];
      end
    end
  end

  assign bus.data_vga       = vga_c;
  assign bus.data_lcd       = lcd_c;
  assign bus.back_ready     = back_ready_q;
  assign bus.swap_pending   = pend_q;
  assign bus.swap_pulse     = swap_q;
  assign bus.front_idx      = front_q;
  assign bus.back_idx       = back_q;
  assign bus.frames_dropped = drop_q;

endmodule
